seq_match_ctrl: RTL and testbench

Run-time controller for the serial Mealy pattern-detection path. It accepts a configuration through a valid/ready handshake: pattern, pattern length, overlap mode and match limit. It then watches a qualified serial bit stream and raises a Mealy match output on the bit that completes the pattern. It counts matches and stops itself when the programmed limit is reached. It sits between the software/config side and the serial input `x`, generalising the fixed 1101 detector into a programmable, sequenced resource.

---
 rtl/seq_match_ctrl.sv | 148 ++++++++++++++
 tb/tb_seq_match_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_match_ctrl
// Brief    : Programmable serial Mealy pattern detector with a config
//            handshake, match counting and a self-stopping match limit.
// Revision : 1.0 - initial release
// ============================================================================
module seq_match_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_max,
    input  logic             stop,
    input  logic             done_ack,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RUN     = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;
    localparam logic [3:0] c_PAT_LEN = 4'(PAT_W);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    // The oldest history bit is never part of a comparison, so only
    // PAT_W-1 bits are kept.
    logic [PAT_W-2:0] r_hist;
    logic [3:0]       r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [3:0]       r_len;
    logic             r_ovl;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_cnt;

    logic [PAT_W-1:0] w_shifted;
    logic [PAT_W-1:0] w_mask;
    logic [3:0]       w_cfg_len;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_cfg_fire;
    logic             w_fill_ok;
    logic             w_hit;
    logic             w_limit;

    assign w_cfg_len  = ((cfg_len == 4'd0) || (cfg_len > c_PAT_LEN)) ? c_PAT_LEN : cfg_len;
    assign w_cfg_fire = cfg_valid && (r_state == c_IDLE);
    assign w_shifted  = {r_hist, x};
    assign w_fill_ok  = (r_fill >= (r_len - 4'd1));
    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_limit    = (r_max != '0) && (w_cnt_inc == r_max);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_hit = x_valid && (r_state == c_RUN) && w_fill_ok
                   && (((w_shifted ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Stop outranks the limit; a match in a stop cycle is still counted below.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (cfg_valid) begin
                    w_next_state = c_RUN;
                end
            end
            c_RUN: begin
                if (stop) begin
                    w_next_state = c_IDLE;
                end else if (w_hit && w_limit) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                if (done_ack) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        z         = w_hit;
        cfg_ready = (r_state == c_IDLE);
        busy      = (r_state == c_RUN);
        done      = (r_state == c_DONE);
        match_cnt = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_pat  <= '0;
            r_len  <= c_PAT_LEN;
            r_ovl  <= 1'b1;
            r_max  <= '0;
        end else if (w_cfg_fire) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_pat  <= cfg_pattern;
            r_len  <= w_cfg_len;
            r_ovl  <= cfg_overlap;
            r_max  <= cfg_max;
        end else if ((r_state == c_RUN) && x_valid) begin
            if (w_hit) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_hit && !r_ovl) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_shifted[PAT_W-2:0];
                if (r_fill != c_PAT_LEN) begin
                    r_fill <= r_fill + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_match_ctrl
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a bit-queue reference model of the detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_match_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [3:0]       cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_max;
    logic             stop;
    logic             done_ack;
    logic             x;
    logic             x_valid;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    seq_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_max     (cfg_max),
        .stop        (stop),
        .done_ack    (done_ack),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 run, 2 done; history is the list of
    // valid bits seen since the last clear.
    int         m_state = 0;
    bit         m_init  = 1'b0;
    bit         m_q[$];
    logic [3:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_max;
    int         m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_hit();
        int         n;
        logic [7:0] v;
        n = m_q.size();
        if (m_state != 1 || !x_valid) return 1'b0;
        if (n < m_len - 1) return 1'b0;
        v = '0;
        v[0] = x;
        for (int k = 1; k < m_len; k++) v[k] = m_q[n-k];
        return int'(v) == (int'(m_pat) & ((1 << m_len) - 1));
    endfunction

    always @(posedge clk) begin
        bit h;
        h = exp_hit();
        if (reset) begin
            m_init  = 1'b1;
            m_state = 0;
            m_q.delete();
            m_cnt   = 0;
            m_pat   = '0;
            m_len   = PAT_W;
            m_ovl   = 1'b1;
            m_max   = 0;
        end else begin
            case (m_state)
                0: if (cfg_valid) begin
                    m_pat   = cfg_pattern;
                    m_len   = (cfg_len == 0 || cfg_len > PAT_W) ? PAT_W : int'(cfg_len);
                    m_ovl   = cfg_overlap;
                    m_max   = int'(cfg_max);
                    m_cnt   = 0;
                    m_q.delete();
                    m_state = 1;
                end
                1: begin
                    if (x_valid) begin
                        if (h && m_cnt != 255) m_cnt++;
                        if (h && !m_ovl) begin
                            m_q.delete();
                        end else begin
                            m_q.push_back(x);
                            if (m_q.size() > 8) void'(m_q.pop_front());
                        end
                    end
                    if (stop) m_state = 0;
                    else if (h && m_max != 0 && m_cnt == m_max) m_state = 2;
                end
                default: if (done_ack) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("z", {31'd0, z}, {31'd0, exp_hit()});
            chk("match_cnt", {24'd0, match_cnt}, m_cnt);
            chk("busy", {31'd0, busy}, {31'd0, m_state == 1});
            chk("done", {31'd0, done}, {31'd0, m_state == 2});
            chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, m_state == 0});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [3:0] p, input logic [3:0] l, input bit o, input int m);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_max     = CNT_W'(m);
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic bitin(input bit b, input bit st, output bit zo);
        x       = b;
        x_valid = 1'b1;
        stop    = st;
        @(negedge clk);
        zo = z;
        tick();
        x_valid = 1'b0;
        stop    = 1'b0;
    endtask

    // bits[n-1] is sent first; zm[i] records z on the i-th sent bit (0-based)
    task automatic send_seq(input int n, input logic [15:0] bits, output logic [15:0] zm);
        bit zb;
        zm = '0;
        for (int i = 0; i < n; i++) begin
            bitin(bits[n-1-i], 1'b0, zb);
            zm[i] = zb;
        end
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        logic [15:0] zm;
        bit          zb;
        reset = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; cfg_max = '0; stop = 1'b0; done_ack = 1'b0;
        x = 1'b0; x_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_cnt", {24'd0, match_cnt}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ready", {31'd0, cfg_ready}, 32'd1);

        // 1101 overlapping: completes on 0-based bits 4 and 7
        do_cfg(4'b1101, 4'd4, 1'b1, 0);
        send_seq(8, 16'b0110_1101, zm);
        chk("t1_z", {16'd0, zm}, 32'h90);
        chk("t1_cnt", {24'd0, match_cnt}, 32'd2);
        pulse_stop();

        do_cfg(4'b0011, 4'd2, 1'b0, 0);
        send_seq(4, 16'b1111, zm);
        chk("t2_z_noovl", {16'd0, zm}, 32'h0A);
        pulse_stop();
        do_cfg(4'b0011, 4'd2, 1'b1, 0);
        send_seq(4, 16'b1111, zm);
        chk("t2_z_ovl", {16'd0, zm}, 32'h0E);
        chk("t2_cnt", {24'd0, match_cnt}, 32'd3);
        pulse_stop();

        do_cfg(4'b1101, 4'd4, 1'b1, 1);
        send_seq(4, 16'b1101, zm);
        chk("t3_z", {16'd0, zm}, 32'h08);
        chk("t3_done", {31'd0, done}, 32'd1);
        send_seq(3, 16'b101, zm);
        chk("t3_z_after", {16'd0, zm}, 32'h0);
        send_seq(4, 16'b1101, zm);
        chk("t3_z_done", {16'd0, zm}, 32'h0);
        chk("t3_cnt", {24'd0, match_cnt}, 32'd1);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        chk("t3_ready", {31'd0, cfg_ready}, 32'd1);

        do_cfg(4'b1101, 4'd4, 1'b1, 0);
        send_seq(3, 16'b110, zm);
        bitin(1'b1, 1'b1, zb);
        chk("t4_z_stop", {31'd0, zb}, 32'd1);
        chk("t4_cnt", {24'd0, match_cnt}, 32'd1);
        chk("t4_idle", {31'd0, cfg_ready}, 32'd1);

        do_cfg(4'b1101, 4'd4, 1'b1, 0);
        cfg_pattern = 4'b0011; cfg_len = 4'd2; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        send_seq(4, 16'b1101, zm);
        chk("t5_cfg_ignored", {16'd0, zm}, 32'h08);
        pulse_stop();
        do_cfg(4'b1001, 4'd0, 1'b1, 0);
        send_seq(4, 16'b1001, zm);
        chk("t5_len0", {16'd0, zm}, 32'h08);
        pulse_stop();

        do_cfg(4'b1101, 4'd4, 1'b1, 0);
        send_seq(3, 16'b110, zm);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_cnt", {24'd0, match_cnt}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        do_cfg(4'b1101, 4'd4, 1'b1, 0);
        bitin(1'b1, 1'b0, zb);
        chk("t6_hist_clr", {31'd0, zb}, 32'd0);
        zm = '0;
        for (int i = 0; i < 4; i++) begin
            x = 1'b0; x_valid = 1'b0;
            repeat (2) begin
                x = 1'($urandom);
                tick();
            end
            bitin((i == 2) ? 1'b0 : 1'b1, 1'b0, zb);
            zm[i] = zb;
        end
        chk("t6_gaps", {16'd0, zm}, 32'h08);
        pulse_stop();

        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_pattern = 4'($urandom);
            cfg_len     = 4'($urandom_range(0, 15));
            if (cfg_len == 4'd1) cfg_len = 4'd2;
            cfg_overlap = 1'($urandom);
            cfg_max     = CNT_W'($urandom_range(0, 3));
            stop        = ($urandom_range(0, 39) == 0);
            done_ack    = ($urandom_range(0, 7) == 0);
            x           = 1'($urandom);
            x_valid     = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0; cfg_valid = 1'b0; stop = 1'b0; done_ack = 1'b0; x_valid = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
